// File: rtl/gb_lcd_tx.sv
// rtl/gb_lcd_tx.sv - Game Boy style LCD transmitter: frame-memory reads to dot-clocked pixel stream
// H_ACTIVE/V_ACTIVE default to the 160x144 panel; they exist only so short rasters can be exercised.
module gb_lcd_tx #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 228,
  parameter int V_TOTAL  = 154,
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 144
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  output logic        fb_rd,
  output logic [14:0] fb_addr,
  input  logic [1:0]  fb_data,
  output logic        gb_pclk,
  output logic        gb_de,
  output logic        gb_hsync,
  output logic        gb_vsync,
  output logic [1:0]  gb_pixel,
  output logic [7:0]  ly,
  output logic        frame_done
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state, state_n;
  logic [DW-1:0] div, div_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic          frame_end;
  logic          active, active_n;
  logic [14:0]   addr_n;

  always_comb begin
    state_n   = state;
    div_n     = div;
    x_n       = x;
    y_n       = y;
    frame_end = (state == S_RUN) && (div == DIV_LAST) && (x == X_LAST) && (y == Y_LAST);
    if (state == S_IDLE) begin
      if (en) begin
        state_n = S_RUN;
        div_n   = '0;
        x_n     = '0;
        y_n     = '0;
      end
    end else begin
      if (div == DIV_LAST) begin
        div_n = '0;
        if (x == X_LAST) begin
          x_n = '0;
          y_n = (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x_n = x + 1'b1;
        end
      end else begin
        div_n = div + 1'b1;
      end
      // en only matters here; mid-frame changes are deliberately ignored
      if (frame_end && !en) state_n = S_IDLE;
    end
  end

  assign active   = (x < X_ACT) && (y < Y_ACT);
  assign active_n = (x_n < X_ACT) && (y_n < Y_ACT);
  assign addr_n   = 15'(y_n) * 15'(H_ACTIVE) + 15'(x_n);

  // Strobes come from next-state values so they line up with the counter cycle they describe;
  // line qualifiers lag one pclk and the pixel two, matching the one-cycle memory latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      div        <= '0;
      x          <= '0;
      y          <= '0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      gb_pclk    <= 1'b0;
      gb_de      <= 1'b0;
      gb_hsync   <= 1'b0;
      gb_vsync   <= 1'b0;
      gb_pixel   <= 2'b00;
      ly         <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      x          <= x_n;
      y          <= y_n;
      gb_pclk    <= (state_n == S_RUN) && (div_n >= DIV_HALF);
      fb_rd      <= (state_n == S_RUN) && (div_n == '0) && active_n;
      frame_done <= (state_n == S_RUN) && (div_n == DIV_LAST) && (x_n == X_LAST) && (y_n == Y_LAST);
      if (state_n == S_IDLE) begin
        fb_addr  <= '0;
        gb_de    <= 1'b0;
        gb_hsync <= 1'b0;
        gb_vsync <= 1'b0;
        gb_pixel <= 2'b00;
        ly       <= 8'd0;
      end else begin
        if ((div_n == '0) && active_n) fb_addr <= addr_n;
        if ((state == S_RUN) && (div == '0)) begin
          gb_de    <= active;
          gb_hsync <= (x == X_LAST);
          gb_vsync <= (y == Y_ACT);
          ly       <= 8'(y);
        end
        if ((state == S_RUN) && (div == DIV_ONE)) gb_pixel <= active ? fb_data : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_gb_lcd_tx.sv
// tb/tb_gb_lcd_tx.sv - self-checking bench for gb_lcd_tx on a shortened raster with a random frame memory
module tb_gb_lcd_tx;

  localparam int D     = 4;
  localparam int HA    = 16;
  localparam int HT    = 20;
  localparam int VA    = 10;
  localparam int VT    = 13;
  localparam int FRAME = D * HT * VT;
  localparam int NPIX  = HA * VA;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fb_rd;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        gb_pclk, gb_de, gb_hsync, gb_vsync, frame_done;
  logic [1:0]  gb_pixel;
  logic [7:0]  ly;

  always #5 pclk = ~pclk;

  gb_lcd_tx #(.CLK_DIV(D), .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .pclk(pclk), .rst(rst), .en(en), .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
    .gb_pclk(gb_pclk), .gb_de(gb_de), .gb_hsync(gb_hsync), .gb_vsync(gb_vsync),
    .gb_pixel(gb_pixel), .ly(ly), .frame_done(frame_done)
  );

  logic [1:0] pattern [NPIX];

  // Synchronous frame memory; garbage whenever no read was issued.
  always @(posedge pclk) begin
    if (fb_rd && int'(fb_addr) < NPIX) fb_data <= pattern[int'(fb_addr)];
    else fb_data <= 2'($urandom);
  end

  int checks = 0;
  int errors = 0;
  bit m_run = 0;
  int t = 0;
  int m_last = 0;
  int cyc = 0;
  int c_rd, c_derise, c_hs, c_vs, c_vblank_de;
  logic prev_pclk = 1'b0;

  // Reference raster is a pure function of the cycle index since the run began.
  function automatic int sd(int tt); return tt % D; endfunction
  function automatic int sx(int tt); return (tt / D) % HT; endfunction
  function automatic int sy(int tt); return (tt / (D * HT)) % VT; endfunction
  function automatic bit act(int tt); return (sx(tt) < HA) && (sy(tt) < VA); endfunction
  function automatic bit fd_at(int tt);
    return (sd(tt) == D - 1) && (sx(tt) == HT - 1) && (sy(tt) == VT - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic e_rd, e_pclk, e_de, e_hs, e_vs, e_fd;
    int e_addr, e_ly, e_pix, p;
    @(posedge pclk);
    if (rst) begin
      m_run = 0; t = 0; m_last = 0;
    end else if (!m_run) begin
      if (en) begin m_run = 1; t = 0; end
    end else if (fd_at(t) && !en) begin
      m_run = 0; t = 0; m_last = 0;
    end else begin
      t++;
    end
    @(negedge pclk);
    cyc++;
    e_rd = 0; e_pclk = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0;
    e_ly = 0; e_pix = 0; e_addr = m_last;
    if (m_run) begin
      e_rd   = (sd(t) == 0) && act(t);
      if (e_rd) begin e_addr = sy(t) * HA + sx(t); m_last = e_addr; end
      e_pclk = sd(t) >= D / 2;
      e_fd   = fd_at(t);
      if (t >= 1) begin
        p    = t - 1;
        e_de = act(p);
        e_hs = sx(p) == HT - 1;
        e_vs = sy(p) == VA;
        e_ly = sy(p);
      end
      if (t >= 2) begin
        p = t - 2;
        e_pix = act(p) ? int'(pattern[sy(p) * HA + sx(p)]) : 0;
      end
      if (e_rd && sx(t) == 0 && sy(t) == 1) chk("addr_x0_y1", fb_addr, HA);
      if (e_rd && sx(t) == HA - 1 && sy(t) == VA - 1) chk("addr_last", fb_addr, NPIX - 1);
    end
    chk("fb_rd", fb_rd, e_rd);
    chk("fb_addr", fb_addr, e_addr);
    chk("gb_pclk", gb_pclk, e_pclk);
    chk("gb_de", gb_de, e_de);
    chk("gb_hsync", gb_hsync, e_hs);
    chk("gb_vsync", gb_vsync, e_vs);
    chk("gb_pixel", gb_pixel, e_pix);
    chk("ly", ly, e_ly);
    chk("frame_done", frame_done, e_fd);
    c_rd += int'(fb_rd);
    if (gb_pclk && !prev_pclk && gb_de) c_derise++;
    c_hs += int'(gb_hsync);
    c_vs += int'(gb_vsync);
    if (gb_de && ly >= VA) c_vblank_de++;
    prev_pclk = gb_pclk;
  endtask

  task automatic wait_fd(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      if (frame_done) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_ly(input string tag, input int v);
    bit seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      if (m_run && ly == 8'(v)) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  int start;
  bit seen2;

  initial begin
    foreach (pattern[i]) pattern[i] = 2'($urandom);

    repeat (3) tick();
    chk("reset_ly", ly, 0);
    chk("reset_addr", fb_addr, 0);
    rst = 1'b0;
    repeat ($urandom_range(2, 5)) tick();
    chk("idle_rd", fb_rd, 0);

    en = 1'b1;
    tick();
    chk("first_rd", fb_rd, 1);
    chk("first_addr", fb_addr, 0);
    chk("first_de", gb_de, 0);
    tick();
    chk("de_rise", gb_de, 1);
    chk("pclk_low_t1", gb_pclk, 0);
    tick();
    chk("pclk_rise", gb_pclk, 1);

    // Full frame between two frame_done pulses, with en toggled randomly except at frame end.
    wait_fd("fd_first");
    c_rd = 0; c_derise = 0; c_hs = 0; c_vs = 0; c_vblank_de = 0;
    start = cyc;
    seen2 = 0;
    for (int i = 0; i < 2 * FRAME && !seen2; i++) begin
      en = fd_at(t) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
      if (frame_done) seen2 = 1;
    end
    chk("fd_second", seen2, 1);
    en = 1'b1;
    chk("frame_period", cyc - start, FRAME);
    chk("rd_per_frame", c_rd, NPIX);
    chk("de_rises_per_frame", c_derise, NPIX);
    chk("hsync_pclks", c_hs, D * VT);
    chk("vsync_pclks", c_vs, D * HT);
    chk("vblank_de", c_vblank_de, 0);

    // Stop request mid-frame: frame completes then everything goes quiet.
    wait_ly("reach_ly5", 5);
    en = 1'b0;
    wait_fd("fd_stop");
    c_rd = 0;
    repeat ($urandom_range(3, 8)) tick();
    chk("stopped_rd_count", c_rd, 0);
    chk("stopped_pclk", gb_pclk, 0);
    chk("stopped_ly", ly, 0);

    // Mid-frame reset with en still high, then restart from address 0.
    en = 1'b1;
    tick();
    chk("restart_rd", fb_rd, 1);
    wait_ly("reach_ly7", 7);
    rst = 1'b1;
    tick();
    chk("rst_rd", fb_rd, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_pclk", gb_pclk, 0);
    chk("rst_de", gb_de, 0);
    chk("rst_hsync", gb_hsync, 0);
    chk("rst_vsync", gb_vsync, 0);
    chk("rst_pixel", gb_pixel, 0);
    chk("rst_ly", ly, 0);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_rd", fb_rd, 1);
    chk("post_rst_addr", fb_addr, 0);
    repeat (FRAME / 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_lcd_tx.md
GB_LCD_TX -- requirements
Module: gb_lcd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving system clocks per pixel slot; even, >= 4.
REQ-002 SHALL have parameter H_TOTAL, default 228, giving pixel slots per line; 160 slots active.
REQ-003 SHALL have parameter V_TOTAL, default 154, giving lines per frame; 144 lines active.
REQ-004 SHALL have port pclk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: run request, sampled only at frame boundaries.
REQ-007 SHALL have port fb_rd, output, 1 bit: frame-memory read strobe.
REQ-008 SHALL have port fb_addr, output, 15 bits: frame-memory read address.
REQ-009 SHALL have port fb_data, input, 2 bits: read data, valid exactly one pclk after fb_rd.
REQ-010 SHALL have port gb_pclk, output, 1 bit: LCD dot clock, a registered square wave.
REQ-011 SHALL have port gb_de, output, 1 bit: active-pixel qualifier.
REQ-012 SHALL have port gb_hsync, output, 1 bit: line-end marker.
REQ-013 SHALL have port gb_vsync, output, 1 bit: frame marker.
REQ-014 SHALL have port gb_pixel, output, 2 bits: shade index.
REQ-015 SHALL have port ly, output, 8 bits: current line 0..V_TOTAL-1.
REQ-016 SHALL have port frame_done, output, 1 bit: one-pclk pulse at end of each frame.

Function
REQ-017 SHALL implement states IDLE and RUN; counters div (0..CLK_DIV-1), x (0..H_TOTAL-1), y (0..V_TOTAL-1).
REQ-018 SHALL leave IDLE for RUN on the cycle after en=1 is seen, with div=x=y=0.
REQ-019 SHALL in RUN advance div every pclk; on div wrap advance x; on x wrap advance y; on y wrap return to 0.
REQ-020 SHALL drive gb_pclk=1 exactly when in RUN and div >= CLK_DIV/2; gb_pclk=0 in IDLE.
REQ-021 SHALL assert fb_rd for one pclk at div==0 of each slot with x<160 and y<144, with fb_addr = y*160+x (range 0..23039).
REQ-022 SHALL hold fb_addr at its last value when fb_rd=0.
REQ-023 SHALL register fb_data into gb_pixel at div==1 of the same slot.
REQ-024 SHALL update gb_de, gb_hsync, gb_vsync and ly only at div==1, so they are stable across the gb_pclk rising edge and hold for a full slot.
REQ-025 SHALL set gb_de=1 for active slots; otherwise gb_de=0 and gb_pixel=0.
REQ-026 SHALL set gb_hsync=1 only for slot x==H_TOTAL-1.
REQ-027 SHALL set gb_vsync=1 for every slot of line y==144 only.
REQ-028 SHALL pulse frame_done at div==CLK_DIV-1 of slot x==H_TOTAL-1 on line y==V_TOTAL-1.
REQ-029 SHALL at that same cycle enter IDLE if en=0 (outputs zero next cycle), else continue at div=x=y=0 with no gap.
REQ-030 SHALL ignore en deassertion mid-frame; the frame always completes.

Reset
REQ-031 SHALL, when rst=1 at any pclk edge including mid-frame, next cycle be in IDLE with div=x=y=0 and all outputs (fb_rd, fb_addr, gb_pclk, gb_de, gb_hsync, gb_vsync, gb_pixel, ly, frame_done) equal to 0.
REQ-032 SHALL give rst priority over en and over frame-end actions in the same cycle.

Verification
REQ-033 SHALL be verified for reset-then-run: rst 3 cycles, en=1 -> first fb_rd one cycle after en is seen, fb_addr=0; gb_de rises 1 cycle later; gb_pclk first rises 2 cycles after fb_rd.
REQ-034 SHALL be verified for frame count: with en held, 140448 pclk (228*154*4) between frame_done pulses, 23040 gb_pclk rising edges with gb_de=1, and 23040 fb_rd strobes per frame.
REQ-035 SHALL be verified for addressing: fb_data driven as a function of fb_addr, checking pixel (x=0,y=1) reads address 160, (159,143) reads 23039, and gb_pixel at each gb_pclk rise matches the model.
REQ-036 SHALL be verified for syncs: gb_hsync high for exactly 4 pclk per line; gb_vsync high for 912 pclk during ly=144; no gb_de during ly 144..153.
REQ-037 SHALL be verified for stop and mid-frame reset: en dropped at ly=50 -> frame finishes, frame_done pulses, then outputs 0 and no fb_rd; rst at ly=70 -> all outputs 0 next cycle, restart at fb_addr=0.
